// File: rtl/axil_apb_master_pkg.sv
// -----------------------------------------------------------------------------
// axi2apb package
// Shared definitions for the AXI4-Lite to APB master bridge.
//   RESP_*          : AXI response codes driven on b_resp / r_resp
//   apb_state_e     : bridge FSM state encoding
//   byte_off_bits() : number of byte-offset address bits for a data width
// -----------------------------------------------------------------------------
package axi2apb;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  // Address bits below the bus word size; these are forced to zero on paddr.
  function automatic int unsigned byte_off_bits(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// -----------------------------------------------------------------------------
// apb_timeout_cnt
// Counts ACCESS-phase cycles and flags the last permitted one.
//   i_clk      : clock
//   i_rst      : asynchronous active-high reset
//   i_clear    : synchronous clear (held while not in ACCESS)
//   i_enable   : count this cycle
//   o_expired  : high in the cycle the count equals TimeoutCycles-1
// TimeoutCycles = 0 disables the timeout; o_expired is then tied low.
// -----------------------------------------------------------------------------
module apb_timeout_cnt #(
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  generate
    if (TimeoutCycles == 0) begin : g_off
      logic w_unused;
      assign w_unused  = ^{i_clk, i_rst, i_clear, i_enable};
      assign o_expired = 1'b0;
    end else begin : g_on
      localparam int unsigned CntWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

      logic [CntWidth-1:0] r_cnt;

      // The first ACCESS cycle sees a count of 0, so expiry at T-1 gives
      // an ACCESS phase of exactly T cycles.
      assign o_expired = (r_cnt == CntWidth'(TimeoutCycles - 1));

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_cnt <= '0;
        end else if (i_clear) begin
          r_cnt <= '0;
        end else if (i_enable && !o_expired) begin
          r_cnt <= r_cnt + CntWidth'(1);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/axil_apb_master.sv
// -----------------------------------------------------------------------------
// axil_apb_master
// AXI4-Lite slave to multi-slave APB master bridge, single clock (apb_clk).
//   apb_clk / apb_rst          : clock, asynchronous active-high reset
//   aw_* / w_* / b_*           : AXI-Lite write address, data, response
//   ar_* / r_*                 : AXI-Lite read address, response
//   paddr/pprot/pwrite/penable : APB control (shared by all slaves)
//   pwdata/pstrb               : APB write data / strobe (zero on reads)
//   psel                       : one-hot slave select
//   pready/pslverr/prdata      : per-slave APB responses
//   timeout_o                  : one-cycle pulse when an access times out
//   busy_o                     : high whenever the FSM is not IDLE
// Slave index is addr[AddrWidth-1:SlotBits]; indices beyond NoApbSlaves get
// DECERR without an APB cycle. Reads and writes alternate under contention.
// -----------------------------------------------------------------------------
module axil_apb_master
  import axi2apb::*;
#(
  parameter int unsigned NoApbSlaves   = 4,
  parameter int unsigned AddrWidth     = 24,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned SlotBits      = 16,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                                   apb_clk,
  input  logic                                   apb_rst,
  input  logic [AddrWidth-1:0]                   aw_addr,
  input  logic [2:0]                             aw_prot,
  input  logic                                   aw_valid,
  output logic                                   aw_ready,
  input  logic [DataWidth-1:0]                   w_data,
  input  logic [DataWidth/8-1:0]                 w_strb,
  input  logic                                   w_valid,
  output logic                                   w_ready,
  output logic [1:0]                             b_resp,
  output logic                                   b_valid,
  input  logic                                   b_ready,
  input  logic [AddrWidth-1:0]                   ar_addr,
  input  logic [2:0]                             ar_prot,
  input  logic                                   ar_valid,
  output logic                                   ar_ready,
  output logic [DataWidth-1:0]                   r_data,
  output logic [1:0]                             r_resp,
  output logic                                   r_valid,
  input  logic                                   r_ready,
  output logic [AddrWidth-1:0]                   paddr,
  output logic [2:0]                             pprot,
  output logic                                   pwrite,
  output logic                                   penable,
  output logic [DataWidth-1:0]                   pwdata,
  output logic [DataWidth/8-1:0]                 pstrb,
  output logic [NoApbSlaves-1:0]                 psel,
  input  logic [NoApbSlaves-1:0]                 pready,
  input  logic [NoApbSlaves-1:0]                 pslverr,
  input  logic [NoApbSlaves-1:0][DataWidth-1:0]  prdata,
  output logic                                   timeout_o,
  output logic                                   busy_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned IdxWidth  = AddrWidth - SlotBits;
  localparam int unsigned SelWidth  = (NoApbSlaves > 1) ? $clog2(NoApbSlaves) : 1;
  localparam int unsigned OffBits   = byte_off_bits(DataWidth);

  apb_state_e r_state;
  apb_state_e w_state_next;

  logic                  r_last_write;   // 0 = read served last (reset value)
  logic                  r_write;
  logic [AddrWidth-1:0]  r_paddr;
  logic [2:0]            r_prot;
  logic [DataWidth-1:0]  r_wdata;
  logic [StrbWidth-1:0]  r_strb;
  logic [SelWidth-1:0]   r_idx;
  logic [1:0]            r_rsp;
  logic [DataWidth-1:0]  r_rdata;

  logic                  w_wr_pend;
  logic                  w_rd_pend;
  logic                  w_grant_wr;
  logic                  w_grant_rd;
  logic                  w_grant;
  logic [AddrWidth-1:0]  w_req_addr;
  logic [IdxWidth-1:0]   w_req_idx;
  logic                  w_mapped;
  logic [AddrWidth-1:0]  w_slot_addr;
  logic [NoApbSlaves-1:0] w_sel_onehot;
  logic                  w_apb_active;
  logic                  w_sel_ready;
  logic                  w_sel_err;
  logic                  w_expired;
  logic                  w_timeout;
  logic                  w_unused_addr;

  // ---------------------------------------------------------------------------
  // Arbitration and decode (only meaningful in IDLE)
  // ---------------------------------------------------------------------------
  assign w_wr_pend  = aw_valid && w_valid;
  assign w_rd_pend  = ar_valid;
  assign w_grant_wr = (r_state == ST_IDLE) && w_wr_pend && (!w_rd_pend || !r_last_write);
  assign w_grant_rd = (r_state == ST_IDLE) && w_rd_pend && (!w_wr_pend || r_last_write);
  assign w_grant    = w_grant_wr || w_grant_rd;

  assign w_req_addr    = w_grant_wr ? aw_addr : ar_addr;
  assign w_req_idx     = w_req_addr[AddrWidth-1:SlotBits];
  assign w_mapped      = (32'(w_req_idx) < NoApbSlaves);
  assign w_unused_addr = ^w_req_addr[OffBits-1:0];

  always_comb begin
    w_slot_addr = '0;
    w_slot_addr[SlotBits-1:OffBits] = w_req_addr[SlotBits-1:OffBits];
  end

  // ---------------------------------------------------------------------------
  // Slave select and response steering
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NoApbSlaves; gi++) begin : g_sel
      assign w_sel_onehot[gi] = (r_idx == SelWidth'(gi));
    end
  endgenerate

  assign w_apb_active = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
  // Masking with the one-hot select discards responses from idle slaves.
  assign w_sel_ready  = |(pready & w_sel_onehot);
  assign w_sel_err    = |(pslverr & w_sel_onehot);
  // pready takes priority over an expiry landing in the same cycle.
  assign w_timeout    = (r_state == ST_ACCESS) && !w_sel_ready && w_expired;

  apb_timeout_cnt #(
    .TimeoutCycles (TimeoutCycles)
  ) u_timeout_cnt (
    .i_clk     (apb_clk),
    .i_rst     (apb_rst),
    .i_clear   (r_state != ST_ACCESS),
    .i_enable  (r_state == ST_ACCESS),
    .o_expired (w_expired)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge apb_clk or posedge apb_rst) begin
    if (apb_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    aw_ready     = 1'b0;
    w_ready      = 1'b0;
    ar_ready     = 1'b0;
    timeout_o    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        aw_ready = w_grant_wr;
        w_ready  = w_grant_wr;
        ar_ready = w_grant_rd;
        if (w_grant) begin
          w_state_next = w_mapped ? ST_SETUP : ST_RESP;
        end
      end
      ST_SETUP: begin
        w_state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (w_sel_ready) begin
          w_state_next = ST_RESP;
        end else if (w_timeout) begin
          timeout_o    = 1'b1;
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (r_write ? b_ready : r_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request capture and response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge apb_clk or posedge apb_rst) begin
    if (apb_rst) begin
      r_last_write <= 1'b0;
      r_write      <= 1'b0;
      r_paddr      <= '0;
      r_prot       <= '0;
      r_wdata      <= '0;
      r_strb       <= '0;
      r_idx        <= '0;
      r_rsp        <= RESP_OKAY;
      r_rdata      <= '0;
    end else if (w_grant) begin
      r_last_write <= w_grant_wr;
      r_write      <= w_grant_wr;
      r_paddr      <= w_slot_addr;
      r_prot       <= w_grant_wr ? aw_prot : ar_prot;
      r_wdata      <= w_grant_wr ? w_data : '0;
      r_strb       <= w_grant_wr ? w_strb : '0;
      r_idx        <= SelWidth'(w_req_idx);
      r_rsp        <= w_mapped ? RESP_OKAY : RESP_DECERR;
      r_rdata      <= '0;
    end else if (r_state == ST_ACCESS) begin
      if (w_sel_ready) begin
        r_rsp   <= w_sel_err ? RESP_SLVERR : RESP_OKAY;
        r_rdata <= r_write ? '0 : prdata[r_idx];
      end else if (w_timeout) begin
        r_rsp   <= RESP_SLVERR;
        r_rdata <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign psel    = w_apb_active ? w_sel_onehot : '0;
  assign penable = (r_state == ST_ACCESS);
  assign paddr   = r_paddr;
  assign pprot   = r_prot;
  assign pwrite  = r_write;
  assign pwdata  = r_wdata;
  assign pstrb   = r_strb;

  assign b_valid = (r_state == ST_RESP) && r_write;
  assign r_valid = (r_state == ST_RESP) && !r_write;
  assign b_resp  = r_rsp;
  assign r_resp  = r_rsp;
  assign r_data  = r_rdata;
  assign busy_o  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_axil_apb_master.sv
module tb_axil_apb_master;

  logic              apb_clk = 1'b0;
  logic              apb_rst;
  logic [23:0]       aw_addr, ar_addr;
  logic [2:0]        aw_prot, ar_prot;
  logic              aw_valid, w_valid, ar_valid, b_ready, r_ready;
  logic              aw_ready, w_ready, ar_ready, b_valid, r_valid;
  logic [31:0]       w_data, r_data, pwdata;
  logic [3:0]        w_strb, pstrb;
  logic [1:0]        b_resp, r_resp;
  logic [23:0]       paddr;
  logic [2:0]        pprot;
  logic              pwrite, penable, timeout_o, busy_o;
  logic [3:0]        psel, pready, pslverr;
  logic [3:0][31:0]  prdata;

  int checks = 0;
  int errors = 0;

  always #5 apb_clk = ~apb_clk;

  axil_apb_master #(
    .NoApbSlaves(4), .AddrWidth(24), .DataWidth(32), .SlotBits(16), .TimeoutCycles(8)
  ) dut (
    .apb_clk(apb_clk), .apb_rst(apb_rst),
    .aw_addr(aw_addr), .aw_prot(aw_prot), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_prot(ar_prot), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready),
    .paddr(paddr), .pprot(pprot), .pwrite(pwrite), .penable(penable),
    .pwdata(pwdata), .pstrb(pstrb), .psel(psel),
    .pready(pready), .pslverr(pslverr), .prdata(prdata),
    .timeout_o(timeout_o), .busy_o(busy_o)
  );

  logic [111:0] all_outs;
  assign all_outs = {aw_ready, w_ready, ar_ready, b_valid, b_resp, r_valid, r_resp, r_data,
                     paddr, pprot, pwrite, penable, pwdata, pstrb, psel, timeout_o, busy_o};

  // APB slave models: slave i raises pready after wait_cfg[i] ACCESS cycles.
  // Unselected slaves drive random pready/pslverr to prove they are ignored.
  int          wait_cfg [4];
  logic [31:0] rdata_cfg [4];
  bit          err_cfg [4];
  int          acc_cnt [4];
  logic [7:0]  noise;

  always @(posedge apb_clk) begin
    for (int i = 0; i < 4; i++)
      acc_cnt[i] <= (psel[i] && penable && !pready[i]) ? acc_cnt[i] + 1 : 0;
  end

  always @(negedge apb_clk) noise <= 8'($urandom());

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (psel[i] && penable) begin
        pready[i]  = (acc_cnt[i] >= wait_cfg[i]);
        pslverr[i] = err_cfg[i];
      end else begin
        pready[i]  = noise[i];
        pslverr[i] = noise[i+4];
      end
      prdata[i] = rdata_cfg[i];
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: what a transaction should produce, from the bridge rules
  // (slot decode, 3-cycle minimum, +1 per wait cycle, 8-cycle ACCESS limit).
  task automatic model(input bit wr, input logic [23:0] addr, input int wt,
                       input logic [31:0] rd, input bit err,
                       output logic [1:0] resp, output logic [31:0] rdata, output int lat,
                       output int acc, output int tmo, output logic [3:0] sel,
                       output logic [23:0] pa);
    int idx;
    idx = int'(addr[23:16]);
    pa  = addr & 24'h00FFFC;
    if (idx >= 4) begin
      resp = 2'b11; rdata = 32'h0; lat = 1; acc = 0; tmo = 0; sel = 4'h0;
    end else begin
      sel = 4'(1 << idx);
      if (wt >= 8) begin
        resp = 2'b10; rdata = 32'h0; lat = 10; acc = 8; tmo = 1;
      end else begin
        resp = err ? 2'b10 : 2'b00; rdata = wr ? 32'h0 : rd; lat = 3 + wt; acc = wt + 1; tmo = 0;
      end
    end
  endtask

  task automatic run_txn(input string name, input bit wr, input logic [23:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                         input int wt, input logic [31:0] rd, input bit err,
                         input logic [1:0] exp_resp, input logic [31:0] exp_rdata,
                         input int exp_lat, input int hold);
    logic [1:0]  m_resp, got_resp;
    logic [31:0] m_rdata, got_data;
    logic [3:0]  m_sel;
    logic [23:0] m_pa;
    logic [1:0]  exp_vld;
    int m_lat, m_acc, m_tmo, idx, lat, acc, tmo;
    bit apb_ok, stable_ok;
    model(wr, addr, wt, rd, err, m_resp, m_rdata, m_lat, m_acc, m_tmo, m_sel, m_pa);
    idx     = int'(addr[23:16]);
    exp_vld = wr ? 2'b10 : 2'b01;
    @(negedge apb_clk);
    for (int i = 0; i < 4; i++) begin
      wait_cfg[i]  = 0;
      rdata_cfg[i] = $urandom();
      err_cfg[i]   = ($urandom_range(0, 1) == 1);
    end
    if (idx < 4) begin
      wait_cfg[idx] = wt; rdata_cfg[idx] = rd; err_cfg[idx] = err;
    end
    if (wr) begin
      aw_addr = addr; aw_prot = prot; w_data = wdata; w_strb = strb;
      aw_valid = 1'b1; w_valid = 1'b1;
    end else begin
      ar_addr = addr; ar_prot = prot; ar_valid = 1'b1;
    end
    #1;
    chk({name, " grant"}, {aw_ready, w_ready, ar_ready}, wr ? 3'b110 : 3'b001);
    @(negedge apb_clk);
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
    lat = 1; acc = 0; tmo = 0; apb_ok = 1'b1;
    while (!(b_valid || r_valid) && lat < 40) begin
      if (!(psel == m_sel && penable == (lat >= 2) && paddr == m_pa && pwrite == wr &&
            pwdata == (wr ? wdata : 32'h0) && pstrb == (wr ? strb : 4'h0) &&
            pprot == prot && busy_o))
        apb_ok = 1'b0;
      if (penable) acc++;
      if (timeout_o) tmo++;
      @(negedge apb_clk);
      lat++;
    end
    got_resp = wr ? b_resp : r_resp;
    got_data = r_data;
    chk({name, " latency"}, 128'(lat), 128'(exp_lat));
    chk({name, " valid"}, {b_valid, r_valid}, exp_vld);
    chk({name, " resp"}, got_resp, exp_resp);
    if (!wr) chk({name, " rdata"}, got_data, exp_rdata);
    chk({name, " access_cycles"}, 128'(acc), 128'(m_acc));
    chk({name, " timeout_pulses"}, 128'(tmo), 128'(m_tmo));
    chk({name, " apb_phase"}, apb_ok, 1'b1);
    chk({name, " psel_in_resp"}, {psel, penable}, 5'h0);
    stable_ok = 1'b1;
    repeat (hold) begin
      @(negedge apb_clk);
      if ({b_valid, r_valid} != exp_vld || (wr ? b_resp : r_resp) != got_resp ||
          (!wr && r_data != got_data))
        stable_ok = 1'b0;
    end
    chk({name, " resp_held"}, stable_ok, 1'b1);
    b_ready = wr; r_ready = !wr;
    @(negedge apb_clk);
    b_ready = 1'b0; r_ready = 1'b0;
    chk({name, " done"}, {b_valid, r_valid, busy_o}, 3'b000);
    $display("txn %-16s %s addr=%06h resp=%0d data=%08h lat=%0d", name, wr ? "WR" : "RD",
             addr, got_resp, got_data, lat);
  endtask

  typedef struct {
    string       name;
    bit          wr;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          wt;
    logic [31:0] rd;
    bit          err;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  m_resp;
    logic [31:0] m_rdata;
    logic [3:0]  m_sel;
    logic [23:0] m_pa;
    int m_lat, m_acc, m_tmo;
    bit r_wr, r_err, bad, seen;
    int r_wt, sel_pick, ngrant, last_cyc, cyc;
    logic [23:0] r_addr;
    logic [31:0] r_rd;

    vecs[0] = '{"wr_slv1",        1'b1, 24'h010004, 32'hDEADBEEF, 4'hF, 3'd0, 0,   32'h0,        1'b0, 2'b00, 32'h0,        3};
    vecs[1] = '{"rd_slv2_wait3",  1'b0, 24'h020010, 32'h0,        4'h0, 3'd2, 3,   32'h12345678, 1'b1, 2'b10, 32'h12345678, 6};
    vecs[2] = '{"rd_unmapped",    1'b0, 24'h050000, 32'h0,        4'h0, 3'd0, 0,   32'h0,        1'b0, 2'b11, 32'h0,        1};
    vecs[3] = '{"wr_timeout",     1'b1, 24'h000000, 32'h0BADF00D, 4'h5, 3'd1, 255, 32'h0,        1'b0, 2'b10, 32'h0,        10};
    vecs[4] = '{"rd_ready_last",  1'b0, 24'h03FFFF, 32'h0,        4'h0, 3'd7, 7,   32'hA5A55A5A, 1'b0, 2'b00, 32'hA5A55A5A, 10};
    vecs[5] = '{"rd_timeout",     1'b0, 24'h000123, 32'h0,        4'h0, 3'd3, 8,   32'hFFFFFFFF, 1'b0, 2'b10, 32'h0,        10};
    vecs[6] = '{"wr_unmapped",    1'b1, 24'hFF0008, 32'h11111111, 4'hF, 3'd0, 0,   32'h0,        1'b0, 2'b11, 32'h0,        1};
    vecs[7] = '{"wr_slverr",      1'b1, 24'h030000, 32'h00000001, 4'h1, 3'd4, 1,   32'h0,        1'b1, 2'b10, 32'h0,        4};

    for (int i = 0; i < 4; i++) begin
      wait_cfg[i] = 0; rdata_cfg[i] = 32'h0; err_cfg[i] = 1'b0;
    end
    aw_addr = '0; ar_addr = '0; aw_prot = '0; ar_prot = '0; w_data = '0; w_strb = '0;
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0; b_ready = 1'b0; r_ready = 1'b0;
    apb_rst = 1'b1;
    repeat (3) @(negedge apb_clk);
    chk("reset_outputs", all_outs, 112'h0);
    apb_rst = 1'b0;
    @(negedge apb_clk);
    chk("idle_after_reset", all_outs, 112'h0);

    // Directed vectors
    for (int v = 0; v < 8; v++)
      run_txn(vecs[v].name, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].strb,
              vecs[v].prot, vecs[v].wt, vecs[v].rd, vecs[v].err,
              vecs[v].exp_resp, vecs[v].exp_rdata, vecs[v].exp_lat, v % 3);

    // A lone aw_valid or lone w_valid must never be accepted
    bad = 1'b0;
    @(negedge apb_clk);
    aw_valid = 1'b1; aw_addr = 24'h010000;
    repeat (4) begin
      @(negedge apb_clk);
      if (aw_ready || w_ready || busy_o) bad = 1'b1;
    end
    aw_valid = 1'b0; w_valid = 1'b1;
    repeat (4) begin
      @(negedge apb_clk);
      if (aw_ready || w_ready || busy_o) bad = 1'b1;
    end
    w_valid = 1'b0;
    chk("lone_valid_ignored", bad, 1'b0);
    $display("txn %-16s lone aw/w valid ignored=%0d", "lone_valid", !bad);

    // Randomized transactions against the reference model
    for (int n = 0; n < 40; n++) begin
      r_wr     = ($urandom_range(0, 1) == 1);
      sel_pick = $urandom_range(0, 5);
      r_addr   = {8'(sel_pick), 16'($urandom())};
      r_wt     = $urandom_range(0, 9);
      r_wt     = (r_wt < 6) ? (r_wt % 4) : ((r_wt < 8) ? 7 : 8 + $urandom_range(0, 3));
      r_rd     = $urandom();
      r_err    = ($urandom_range(0, 1) == 1);
      model(r_wr, r_addr, r_wt, r_rd, r_err, m_resp, m_rdata, m_lat, m_acc, m_tmo, m_sel, m_pa);
      run_txn($sformatf("rand_%0d", n), r_wr, r_addr, $urandom(), 4'($urandom()), 3'($urandom()),
              r_wt, r_rd, r_err, m_resp, m_rdata, m_lat, $urandom_range(0, 2));
    end

    // Contended arbitration from reset: W,R,W,R,... at one grant per 4 cycles
    @(negedge apb_clk);
    apb_rst = 1'b1;
    @(negedge apb_clk);
    apb_rst = 1'b0;
    for (int i = 0; i < 4; i++) wait_cfg[i] = 0;
    aw_addr = 24'h010000; ar_addr = 24'h020000; w_data = 32'hCAFE0000; w_strb = 4'hF;
    b_ready = 1'b1; r_ready = 1'b1;
    aw_valid = 1'b1; w_valid = 1'b1; ar_valid = 1'b1;
    #1;
    ngrant = 0; cyc = 0; last_cyc = 0;
    while (ngrant < 10 && cyc < 100) begin
      if (aw_ready || ar_ready) begin
        chk($sformatf("arb_grant_%0d", ngrant), {aw_ready, w_ready, ar_ready},
            (ngrant % 2 == 0) ? 3'b110 : 3'b001);
        if (ngrant > 0) chk($sformatf("arb_period_%0d", ngrant), 128'(cyc - last_cyc), 128'd4);
        $display("txn %-16s grant %0d type=%s cycle=%0d", "arbitration", ngrant,
                 aw_ready ? "W" : "R", cyc);
        last_cyc = cyc;
        ngrant++;
      end
      @(negedge apb_clk);
      cyc++;
    end
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
    chk("arb_grant_count", 128'(ngrant), 128'd10);
    cyc = 0;
    while (busy_o && cyc < 40) begin
      @(negedge apb_clk);
      cyc++;
    end
    b_ready = 1'b0; r_ready = 1'b0;
    chk("arb_drained", busy_o, 1'b0);

    // Reset asserted during ACCESS drops the access without a response
    @(negedge apb_clk);
    wait_cfg[0] = 255;
    aw_addr = 24'h000040; w_data = 32'h55AA55AA; w_strb = 4'hF; aw_prot = 3'd0;
    aw_valid = 1'b1; w_valid = 1'b1;
    @(negedge apb_clk);
    aw_valid = 1'b0; w_valid = 1'b0;
    repeat (3) @(negedge apb_clk);
    chk("rst_mid_in_access", {psel, penable}, 5'b0001_1);
    apb_rst = 1'b1;
    #1;
    chk("rst_mid_outputs_zero", all_outs, 112'h0);
    @(negedge apb_clk);
    apb_rst = 1'b0;
    b_ready = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge apb_clk);
      if (b_valid || busy_o) seen = 1'b1;
    end
    b_ready = 1'b0;
    chk("rst_mid_no_response", seen, 1'b0);
    $display("txn %-16s reset during ACCESS, response seen=%0d", "rst_mid", seen);
    run_txn("wr_after_reset", 1'b1, 24'h020008, 32'h87654321, 4'hC, 3'd2, 1, 32'h0, 1'b0,
            2'b00, 32'h0, 4, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
